fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_pkg.sv | 33 +++
 rtl/fetch_pc.sv | 30 +++
 rtl/fetch_stage.sv | 144 ++++++++++++++
 tb/tb_fetch_stage.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// ----------------------------------------------------------------------------
// fetch_pkg: shared opcodes, fetch FSM state encodings and reset constants.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package fetch_pkg;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_WAIT   = 3'd1,
        ST_HOLD   = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_HALTED = 3'd4
    } state_t;

endpackage

`default_nettype wire

// File: rtl/fetch_pc.sv
// ----------------------------------------------------------------------------
// fetch_pc: program counter register with hold / +4 / redirect-target mux.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module fetch_pc
    import fetch_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        advance,
    input  logic        load,
    input  logic [31:0] target,
    output logic [31:0] pc
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= target & ~32'h0000_0003;
        end else if (advance) begin
            pc <= pc + 32'd4;
        end
    end

endmodule

`default_nettype wire

// File: rtl/fetch_stage.sv
// ----------------------------------------------------------------------------
// fetch_stage: instruction fetch FSM driving the instruction memory and IF/ID.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module fetch_stage
    import fetch_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    input  logic        halt,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_rdata,
    output logic        ifid_valid,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_inst,
    output logic [31:0] fetched_count,
    output logic        halted
);

    state_t      state;
    state_t      next_state;
    logic [31:0] pc;
    logic [31:0] pending_inst;
    logic [31:0] deliver_inst;
    logic        deliver;
    logic        capture;
    logic        pc_load;
    logic        active;

    assign active    = (state != ST_HALTED);
    assign halted    = (state == ST_HALTED);
    assign imem_addr = pc;
    // Suppress the request when halt/redirect arrive so no stale fetch is issued.
    assign imem_req  = (state == ST_FETCH) && !halt && !redirect;

    fetch_pc u_pc (
        .clk     (clk),
        .reset   (reset),
        .advance (deliver),
        .load    (pc_load),
        .target  (redirect_target),
        .pc      (pc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_FETCH;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state   = state;
        deliver      = 1'b0;
        capture      = 1'b0;
        pc_load      = 1'b0;
        deliver_inst = pending_inst;
        if (active && halt) begin
            next_state = ST_HALTED;
        end else if (active && redirect) begin
            pc_load = 1'b1;
            // An outstanding request whose response has not yet arrived must be drained.
            if ((state == ST_WAIT || state == ST_DRAIN) && !imem_resp_valid) begin
                next_state = ST_DRAIN;
            end else begin
                next_state = ST_FETCH;
            end
        end else begin
            case (state)
                ST_FETCH: begin
                    if (imem_ready) begin
                        next_state = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (imem_resp_valid) begin
                        if (stall) begin
                            capture    = 1'b1;
                            next_state = ST_HOLD;
                        end else begin
                            deliver      = 1'b1;
                            deliver_inst = imem_rdata;
                            next_state   = ST_FETCH;
                        end
                    end
                end
                ST_HOLD: begin
                    if (!stall) begin
                        deliver    = 1'b1;
                        next_state = ST_FETCH;
                    end
                end
                ST_DRAIN: begin
                    if (imem_resp_valid) begin
                        next_state = ST_FETCH;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ifid_valid    <= 1'b0;
            ifid_pc       <= RESET_PC;
            ifid_inst     <= NOP_INST;
            pending_inst  <= 32'h0;
            fetched_count <= 32'h0;
        end else if (active) begin
            if (halt) begin
                ifid_valid <= 1'b0;
            end else if (redirect) begin
                ifid_valid   <= 1'b0;
                ifid_inst    <= NOP_INST;
                pending_inst <= 32'h0;
            end else if (deliver) begin
                ifid_valid    <= 1'b1;
                ifid_pc       <= pc;
                ifid_inst     <= deliver_inst;
                fetched_count <= fetched_count + 32'd1;
            end else begin
                if (capture) begin
                    pending_inst <= imem_rdata;
                end
                if (!stall) begin
                    ifid_valid <= 1'b0;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// ----------------------------------------------------------------------------
// tb_fetch_stage: directed self-checking bench for fetch_stage.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_fetch_stage;
    import fetch_pkg::*;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_target;
    logic        halt;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_rdata;
    logic        ifid_valid;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_inst;
    logic [31:0] fetched_count;
    logic        halted;

    int errors = 0;
    int checks = 0;

    fetch_stage dut (
        .clk             (clk),
        .reset           (reset),
        .stall           (stall),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .halt            (halt),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ready      (imem_ready),
        .imem_resp_valid (imem_resp_valid),
        .imem_rdata      (imem_rdata),
        .ifid_valid      (ifid_valid),
        .ifid_pc         (ifid_pc),
        .ifid_inst       (ifid_inst),
        .fetched_count   (fetched_count),
        .halted          (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #3;
        checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", ifid_valid); end
        checks++; if (ifid_inst !== 32'h00000013) begin errors++; $display("FAIL rst_inst got %h exp 00000013", ifid_inst); end
        checks++; if (ifid_pc !== 32'h0) begin errors++; $display("FAIL rst_ifid_pc got %h exp 0", ifid_pc); end
        checks++; if (fetched_count !== 32'h0) begin errors++; $display("FAIL rst_count got %0d exp 0", fetched_count); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL rst_halted got %b exp 0", halted); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL rst_req got %b/%h exp 1/0", imem_req, imem_addr); end
        do_reset();
    endtask

    task automatic test_basic_fetch();
        imem_ready = 1'b1;
        cyc();
        checks++; if (dut.state !== ST_WAIT || imem_req !== 1'b0) begin errors++; $display("FAIL basic_wait got state %0d req %b exp 1/0", dut.state, imem_req); end
        imem_resp_valid = 1'b1; imem_rdata = 32'h00500093;
        cyc();
        imem_resp_valid = 1'b0;
        checks++; if (ifid_valid !== 1'b1 || ifid_pc !== 32'h0 || ifid_inst !== 32'h00500093) begin errors++; $display("FAIL basic_first got %b %h %h exp 1 0 00500093", ifid_valid, ifid_pc, ifid_inst); end
        checks++; if (imem_addr !== 32'h4 || fetched_count !== 32'd1) begin errors++; $display("FAIL basic_addr4 got %h cnt %0d exp 4 cnt 1", imem_addr, fetched_count); end
        cyc();
        checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL basic_bubble got %b exp 0", ifid_valid); end
        imem_resp_valid = 1'b1; imem_rdata = 32'h00a00113;
        cyc();
        imem_resp_valid = 1'b0;
        checks++; if (ifid_valid !== 1'b1 || ifid_pc !== 32'h4 || ifid_inst !== 32'h00a00113) begin errors++; $display("FAIL basic_second got %b %h %h exp 1 4 00a00113", ifid_valid, ifid_pc, ifid_inst); end
        checks++; if (imem_addr !== 32'h8 || fetched_count !== 32'd2) begin errors++; $display("FAIL basic_addr8 got %h cnt %0d exp 8 cnt 2", imem_addr, fetched_count); end
    endtask

    task automatic test_stall_hold();
        cyc();
        stall = 1'b1; imem_resp_valid = 1'b1; imem_rdata = 32'h00308193;
        cyc();
        imem_resp_valid = 1'b0;
        checks++; if (dut.state !== ST_HOLD) begin errors++; $display("FAIL stall_hold got %0d exp %0d", dut.state, ST_HOLD); end
        cyc();
        cyc();
        checks++; if (dut.state !== ST_HOLD || ifid_pc !== 32'h4 || ifid_inst !== 32'h00a00113 || ifid_valid !== 1'b0) begin errors++; $display("FAIL stall_ifid got st %0d %b %h %h exp HOLD 0 4 00a00113", dut.state, ifid_valid, ifid_pc, ifid_inst); end
        checks++; if (fetched_count !== 32'd2 || imem_req !== 1'b0) begin errors++; $display("FAIL stall_count got %0d req %b exp 2 0", fetched_count, imem_req); end
        stall = 1'b0;
        cyc();
        checks++; if (ifid_valid !== 1'b1 || ifid_pc !== 32'h8 || ifid_inst !== 32'h00308193) begin errors++; $display("FAIL stall_release got %b %h %h exp 1 8 00308193", ifid_valid, ifid_pc, ifid_inst); end
        checks++; if (fetched_count !== 32'd3 || imem_addr !== 32'hc) begin errors++; $display("FAIL stall_cnt3 got %0d %h exp 3 c", fetched_count, imem_addr); end
        cyc();
        checks++; if (ifid_valid !== 1'b0 || fetched_count !== 32'd3) begin errors++; $display("FAIL stall_once got %b %0d exp 0 3", ifid_valid, fetched_count); end
    endtask

    task automatic test_redirect_wait();
        redirect = 1'b1; redirect_target = 32'h00000103;
        cyc();
        redirect = 1'b0;
        checks++; if (imem_addr !== 32'h100 || ifid_valid !== 1'b0 || ifid_inst !== 32'h00000013) begin errors++; $display("FAIL redir_flush got %h %b %h exp 100 0 00000013", imem_addr, ifid_valid, ifid_inst); end
        checks++; if (dut.state !== ST_DRAIN || imem_req !== 1'b0) begin errors++; $display("FAIL redir_drain got %0d req %b exp %0d 0", dut.state, imem_req, ST_DRAIN); end
        imem_resp_valid = 1'b1; imem_rdata = 32'hdeadbeef;
        cyc();
        imem_resp_valid = 1'b0;
        checks++; if (dut.state !== ST_FETCH || ifid_valid !== 1'b0 || fetched_count !== 32'd3) begin errors++; $display("FAIL redir_discard got %0d %b %0d exp FETCH 0 3", dut.state, ifid_valid, fetched_count); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin errors++; $display("FAIL redir_refetch got %b %h exp 1 100", imem_req, imem_addr); end
    endtask

    task automatic test_redirect_priority();
        cyc();
        stall = 1'b1; imem_resp_valid = 1'b1; imem_rdata = 32'h11111111;
        redirect = 1'b1; redirect_target = 32'h00000200;
        cyc();
        stall = 1'b0; imem_resp_valid = 1'b0; redirect = 1'b0;
        checks++; if (dut.state !== ST_FETCH || dut.pending_inst !== 32'h0) begin errors++; $display("FAIL prio_state got %0d %h exp FETCH 0", dut.state, dut.pending_inst); end
        checks++; if (imem_addr !== 32'h200 || ifid_valid !== 1'b0 || fetched_count !== 32'd3) begin errors++; $display("FAIL prio_flush got %h %b %0d exp 200 0 3", imem_addr, ifid_valid, fetched_count); end
        cyc();
        imem_resp_valid = 1'b1; imem_rdata = 32'h00000033;
        cyc();
        imem_resp_valid = 1'b0;
        checks++; if (ifid_pc !== 32'h200 || ifid_inst !== 32'h00000033 || fetched_count !== 32'd4) begin errors++; $display("FAIL prio_next got %h %h %0d exp 200 00000033 4", ifid_pc, ifid_inst, fetched_count); end
    endtask

    task automatic test_halt();
        cyc();
        halt = 1'b1;
        #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL halt_req_comb got %b exp 0", imem_req); end
        cyc();
        halt = 1'b0;
        checks++; if (halted !== 1'b1 || imem_req !== 1'b0 || ifid_valid !== 1'b0) begin errors++; $display("FAIL halt_enter got %b %b %b exp 1 0 0", halted, imem_req, ifid_valid); end
        imem_resp_valid = 1'b1; imem_rdata = 32'h22222222; redirect = 1'b1; redirect_target = 32'h300;
        cyc();
        cyc();
        imem_resp_valid = 1'b0; redirect = 1'b0;
        checks++; if (halted !== 1'b1 || fetched_count !== 32'd4 || ifid_valid !== 1'b0) begin errors++; $display("FAIL halt_frozen got %b %0d %b exp 1 4 0", halted, fetched_count, ifid_valid); end
        checks++; if (imem_req !== 1'b0 || imem_addr !== 32'h204 || ifid_inst !== 32'h00000033) begin errors++; $display("FAIL halt_ignore got %b %h %h exp 0 204 00000033", imem_req, imem_addr, ifid_inst); end
    endtask

    task automatic test_async_reset();
        do_reset();
        imem_ready = 1'b1;
        cyc();
        imem_resp_valid = 1'b1; imem_rdata = 32'h00100093;
        cyc();
        imem_resp_valid = 1'b0;
        checks++; if (halted !== 1'b0 || fetched_count !== 32'd1 || ifid_valid !== 1'b1) begin errors++; $display("FAIL areset_pre got %b %0d %b exp 0 1 1", halted, fetched_count, ifid_valid); end
        cyc();
        checks++; if (dut.state !== ST_WAIT || imem_addr !== 32'h4) begin errors++; $display("FAIL areset_wait got %0d %h exp WAIT 4", dut.state, imem_addr); end
        #2;
        reset = 1'b1;
        #1;
        checks++; if (ifid_valid !== 1'b0 || fetched_count !== 32'd0 || ifid_pc !== 32'h0 || ifid_inst !== 32'h00000013) begin errors++; $display("FAIL areset_now got %b %0d %h %h exp 0 0 0 00000013", ifid_valid, fetched_count, ifid_pc, ifid_inst); end
        checks++; if (dut.state !== ST_FETCH || imem_addr !== 32'h0 || imem_req !== 1'b1) begin errors++; $display("FAIL areset_fsm got %0d %h %b exp FETCH 0 1", dut.state, imem_addr, imem_req); end
        imem_resp_valid = 1'b1; imem_rdata = 32'h33333333;
        reset = 1'b0;
        cyc();
        imem_resp_valid = 1'b0;
        checks++; if (dut.state !== ST_WAIT || fetched_count !== 32'd0 || ifid_valid !== 1'b0 || imem_addr !== 32'h0) begin errors++; $display("FAIL areset_after got %0d %0d %b %h exp WAIT 0 0 0", dut.state, fetched_count, ifid_valid, imem_addr); end
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_target = 32'h0;
        halt = 1'b0; imem_ready = 1'b0; imem_resp_valid = 1'b0; imem_rdata = 32'h0;
        test_reset();
        test_basic_fetch();
        test_stall_hold();
        test_redirect_wait();
        test_redirect_priority();
        test_halt();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got running exp finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
